lockin_tracker: RTL

//  Next-generation lock-in qualifier for the clks_alot recovery path.
//  - Classifies each polarity-filtered edge against the active rate and a drift window.
//  - Runs an explicit acquire/lock/holdover FSM with miss tolerance.
//  - Keeps a running average of signed drift over a parametrised window for rate trimming.
//  - Sits between the rate counter and the rate register / NCO trim logic.

---
 rtl/lockin_tracker_pkg.sv | 38 +++
 rtl/lockin_tracker_drift_averager.sv | 64 ++++++
 rtl/lockin_tracker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lockin_tracker_pkg.sv
// rtl/lockin_tracker_pkg.sv - shared types and saturating helpers for the lock-in tracker
// Contents:
//   lockin_state_e     qualifier FSM states
//   drift_direction_e  side of the nominal rate an edge landed on
//   sat_add / sat_sub  32-bit saturating helpers (clamp to lim / floor at 0)
package lockin_tracker_pkg;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2,
        HOLDOVER  = 2'd3
    } lockin_state_e;

    typedef enum logic {
        EARLY = 1'b0,
        LATE  = 1'b1
    } drift_direction_e;

    // a + b computed one bit wider so the carry is visible, then clamped to lim
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        if (a > b) begin
            return a - b;
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/lockin_tracker_drift_averager.sv
// rtl/lockin_tracker_drift_averager.sv - running mean of signed drift over DEPTH samples
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   clr_i            synchronous clear of buffer, sum, fill count and outputs
//   push_i           accept sample_i this cycle
//   sample_i         signed drift sample
//   avg_o            signed mean (registered, floor via arithmetic shift)
//   avg_valid_o      DEPTH samples accumulated since the last clear
module lockin_tracker_drift_averager #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clr_i,
    input  logic                push_i,
    input  logic signed [W-1:0] sample_i,
    output logic signed [W-1:0] avg_o,
    output logic                avg_valid_o
);
    localparam int LOG   = $clog2(DEPTH);
    localparam int SUM_W = W + LOG;
    localparam logic [LOG:0] FULL = (LOG + 1)'(DEPTH);

    logic signed [W-1:0]     mem [DEPTH];
    logic [LOG-1:0]          ptr;
    logic [LOG:0]            fill;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_next;

    // Unwritten slots hold zero, so subtracting the slot being overwritten is
    // correct both while filling and once the buffer has wrapped.
    assign sum_next = sum + {{LOG{sample_i[W-1]}}, sample_i} - {{LOG{mem[ptr][W-1]}}, mem[ptr]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr         <= '0;
            fill        <= '0;
            sum         <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr         <= '0;
            fill        <= '0;
            sum         <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
        end else if (push_i) begin
            mem[ptr] <= sample_i;
            ptr      <= ptr + LOG'(1);
            sum      <= sum_next;
            avg_o    <= W'(sum_next >>> LOG);
            if (fill != FULL) begin
                fill <= fill + (LOG + 1)'(1);
            end
            if (fill == FULL - (LOG + 1)'(1)) begin
                avg_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lockin_tracker.sv
// rtl/lockin_tracker.sv - edge-rate lock-in qualifier with holdover and drift averaging
// Ports:
//   clk_i, rst_n_i, clk_en_i               clock, async active-low reset, clock enable
//   lockin_en_i, clear_state_i, event_i    event gating, synchronous clear, edge strobe
//   rate_accumulator_i, active_rate_i      measured interval and current period estimate
//   active_rate_valid_i, drift_window_i    estimate valid, +/- tolerance
//   required_lockin_i                      in-window events needed to lock (0 -> 1)
//   full_drift_en_i, active_drift_dir_i    window side selection
//   state_o, locked_o, lock_lost_o         FSM state and status
//   update_rate_o, rate_violation_o, smaller_bit_o   per-event strobes (combinational)
//   drift_dir_o, drift_amount_o            direction and magnitude of accumulator vs rate
//   avg_drift_o, avg_valid_o               running mean drift (late positive)
module lockin_tracker
    import lockin_tracker_pkg::*;
#(
    parameter int RATE_W     = 16,
    parameter int AVG_DEPTH  = 8,
    parameter int MISS_LIMIT = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clk_en_i,
    input  logic                     lockin_en_i,
    input  logic                     clear_state_i,
    input  logic                     event_i,
    input  logic [RATE_W-1:0]        rate_accumulator_i,
    input  logic [RATE_W-1:0]        active_rate_i,
    input  logic                     active_rate_valid_i,
    input  logic [RATE_W-1:0]        drift_window_i,
    input  logic [RATE_W-1:0]        required_lockin_i,
    input  logic                     full_drift_en_i,
    input  drift_direction_e         active_drift_dir_i,
    output lockin_state_e            state_o,
    output logic                     locked_o,
    output logic                     lock_lost_o,
    output logic                     update_rate_o,
    output logic                     rate_violation_o,
    output logic                     smaller_bit_o,
    output drift_direction_e         drift_dir_o,
    output logic [RATE_W-1:0]        drift_amount_o,
    output logic signed [RATE_W:0]   avg_drift_o,
    output logic                     avg_valid_o
);
    localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [RATE_W-1:0] RATE_MAX = '1;
    localparam logic [RATE_W-1:0] ONE      = RATE_W'(1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

    lockin_state_e         state_q, state_d;
    logic [RATE_W-1:0]     cnt_q, cnt_d, cnt_inc, req_eff;
    logic [MISS_W-1:0]     miss_q, miss_d, miss_inc;
    logic [RATE_W-1:0]     upper, lower, half_upper;
    logic                  ev, late_en, early_en, in_win, small_hit, lost_d, push;
    logic signed [RATE_W:0] drift_s;

    assign ev       = clk_en_i & lockin_en_i & event_i & ~clear_state_i;
    assign late_en  = full_drift_en_i | (active_drift_dir_i == LATE);
    assign early_en = full_drift_en_i | (active_drift_dir_i == EARLY);

    assign upper = late_en
        ? RATE_W'(sat_add(32'(active_rate_i), 32'(drift_window_i), 32'(RATE_MAX)))
        : active_rate_i;
    assign lower = early_en
        ? RATE_W'(sat_sub(32'(active_rate_i), 32'(drift_window_i)))
        : active_rate_i;
    assign half_upper = RATE_W'(sat_add(32'(active_rate_i >> 1),
                                        late_en ? 32'(drift_window_i) : 32'd0, 32'(RATE_MAX)));

    assign in_win    = (rate_accumulator_i >= lower) && (rate_accumulator_i <= upper);
    assign small_hit = active_rate_valid_i && (rate_accumulator_i <= half_upper);

    // Strobes are gated by rst_n_i so downstream rate logic sees nothing during reset.
    assign rate_violation_o = rst_n_i & ev & active_rate_valid_i & ~in_win;
    assign smaller_bit_o    = rst_n_i & ev & small_hit;
    assign update_rate_o    = rst_n_i & ev &
                              ((active_rate_valid_i & in_win) | small_hit | ~active_rate_valid_i);

    assign drift_dir_o    = (rate_accumulator_i > active_rate_i) ? LATE : EARLY;
    assign drift_amount_o = (rate_accumulator_i > active_rate_i)
                            ? rate_accumulator_i - active_rate_i
                            : active_rate_i - rate_accumulator_i;
    assign drift_s        = {1'b0, rate_accumulator_i} - {1'b0, active_rate_i};

    assign req_eff  = (required_lockin_i == '0) ? ONE : required_lockin_i;
    assign cnt_inc  = RATE_W'(sat_add(32'(cnt_q), 32'd1, 32'(RATE_MAX)));
    assign miss_inc = (miss_q == MISS_MAX) ? miss_q : miss_q + MISS_W'(1);
    assign push     = ev & active_rate_valid_i & in_win & (state_q != UNLOCKED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        lost_d  = 1'b0;
        if (clear_state_i) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
            miss_d  = '0;
        end else if (ev) begin
            if (!active_rate_valid_i) begin
                state_d = UNLOCKED;
                cnt_d   = '0;
                miss_d  = '0;
            end else begin
                case (state_q)
                    UNLOCKED: begin
                        if (in_win) begin
                            cnt_d   = ONE;
                            state_d = (req_eff <= ONE) ? LOCKED : ACQUIRING;
                        end
                    end
                    ACQUIRING: begin
                        if (in_win) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= req_eff) state_d = LOCKED;
                        end else begin
                            state_d = UNLOCKED;
                            cnt_d   = '0;
                        end
                    end
                    LOCKED: begin
                        if (in_win) begin
                            miss_d = '0;
                        end else if (MISS_LIMIT == 1) begin
                            state_d = UNLOCKED;
                            cnt_d   = '0;
                            miss_d  = '0;
                            lost_d  = 1'b1;
                        end else begin
                            state_d = HOLDOVER;
                            miss_d  = MISS_W'(1);
                        end
                    end
                    HOLDOVER: begin
                        if (in_win) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end else if (miss_inc >= MISS_MAX) begin
                            state_d = UNLOCKED;
                            cnt_d   = '0;
                            miss_d  = '0;
                            lost_d  = 1'b1;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                    default: state_d = UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= UNLOCKED;
            cnt_q       <= '0;
            miss_q      <= '0;
            lock_lost_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            lock_lost_o <= lost_d;
        end
    end

    assign state_o  = state_q;
    assign locked_o = (state_q == LOCKED) || (state_q == HOLDOVER);

    // Holding the averager clear whenever the FSM is (or is about to be) unlocked
    // restarts the window from empty on every fresh acquisition.
    lockin_tracker_drift_averager #(
        .W     (RATE_W + 1),
        .DEPTH (AVG_DEPTH)
    ) u_avg (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (state_d == UNLOCKED),
        .push_i      (push),
        .sample_i    (drift_s),
        .avg_o       (avg_drift_o),
        .avg_valid_o (avg_valid_o)
    );

endmodule
